fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Read-side consumer of the 256x8 byte FIFO; drains it onto a UART serial line.
//  Pops one byte when the FIFO is non-empty, then sends an 8N1 frame: start bit, 8 data bits LSB first, stop bit.
//  Repeats until the FIFO is empty.
//  Sits between the FIFO (rd/rdata/empty) and the board TX pin.
// PARAMETERS
//  CLK_FREQ  100_000_000  system clock frequency, Hz
//  BAUD      9600         line rate, bit/s
//  BIT_CYC   CLK_FREQ/BAUD (localparam, integer truncation)  clocks per bit; must be >= 2
// PORTS
//  clk         in   1  system clock, rising edge; the only clock
//  rst         in   1  asynchronous, active-low reset
//  fifo_empty  in   1  FIFO empty flag
//  fifo_rdata  in   8  FIFO read data; registered, valid the cycle after fifo_rd
//  fifo_rd     out  1  pop strobe to FIFO, one-cycle pulse
//  tx          out  1  serial output, idle high
//  tx_busy     out  1  high from the POP state through the end of the STOP state
//  tx_done     out  1  one-cycle pulse on the last clock of each stop bit
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done=0.
//    Bit counter and baud counter clear to 0; shift register clears to 8'h00.
//  FSM states: IDLE, POP, LATCH, START, DATA, STOP.
//  IDLE:  tx=1. If fifo_empty=0 -> POP, else stay in IDLE.
//  POP:   fifo_rd=1 for exactly this cycle -> LATCH. fifo_empty is not re-sampled here.
//  LATCH: shift_reg <= fifo_rdata; baud_cnt <= 0 -> START.
//  START: tx=0 for BIT_CYC clocks -> DATA with bit_idx=0.
//  DATA:  tx=shift_reg[bit_idx], each bit held BIT_CYC clocks.
//    bit_idx 0..7; after bit 7 -> STOP.
//  STOP:  tx=1 for BIT_CYC clocks. On the last clock, tx_done=1.
//    Then -> POP if fifo_empty=0, else -> IDLE.
//  Baud counter:
//    Counts 0..BIT_CYC-1 only in START/DATA/STOP; wraps to 0 at each bit boundary.
//    Held at 0 in IDLE/POP/LATCH.
//    A bit boundary occurs exactly when baud_cnt==BIT_CYC-1.
//  Latency:
//    From fifo_empty falling (sampled in IDLE) to the tx falling edge: 3 clocks (IDLE, POP, LATCH).
//    Frame length: exactly 10*BIT_CYC clocks.
//  Back-to-back frames: 2 extra idle-high clocks (POP, LATCH) between the stop bit and the next start bit.
//  At most one fifo_rd per frame. fifo_rd is never asserted while fifo_empty=1 was sampled.
//  fifo_rdata is ignored in every state except LATCH.
//  Reset mid-frame: tx returns high immediately (async). The in-flight byte is lost and is not re-popped.
//  tx is a registered output: no combinational path from any input to tx.
// STRUCTURE
//  Shared package (uart_pkg): FSM state encodings, 8N1 frame constants (DATA_BITS=8).
//    The same package is used by the matching UART receiver.
//  One sub-module: uart_baud_cnt.
//    Parameter BIT_CYC; ports clk, rst, en, tick.
//    tick is high when the count equals BIT_CYC-1; the count clears when en=0.
//  FSM, shift register and bit index live in the top module.
// TESTING  (bench uses CLK_FREQ=1_000_000, BAUD=100_000 -> BIT_CYC=10; FIFO behavioural model)
//  1. Reset, FIFO empty, run 100 clk -> tx=1, fifo_rd never asserted, tx_busy=0.
//  2. Push 8'hA5 -> one fifo_rd pulse; tx falls 3 clk after empty deasserts.
//     Line reads 0,1,0,1,0,0,1,0,1,1 (start, bits 0-7 LSB first, stop), each 10 clk.
//     tx_done pulses once at clk 100 of the frame.
//  3. Push 8'h00, 8'hFF, 8'h3C back-to-back -> three frames, 2 high clocks between them.
//     Exactly 3 fifo_rd pulses; decoded bytes 00, FF, 3C; FIFO empty afterwards, state IDLE.
//  4. Assert rst=0 during bit 4 of 8'h55 -> tx=1 same cycle, busy=0.
//     After release with FIFO empty: no further fifo_rd, tx stays 1.
//  5. Refill the FIFO in the same cycle tx_done pulses -> next frame starts with no extra IDLE cycle.
//  6. Scoreboard: 256 random bytes with random push gaps -> serial decode matches push order; no underflow reads.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART transmitter and its matching receiver:
// FSM state encoding, frame constants and a baud-divisor helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    // 8N1 framing: one start bit, DATA_BITS data bits LSB first, one stop bit.
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = DATA_BITS + 2;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LATCH = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_e;

    // Clocks per bit; integer truncation, the result must be at least 2.
    function automatic int calc_bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter. Counts 0..BIT_CYC-1 while en=1 and wraps at each bit
// boundary; held at 0 whenever en=0.
// Ports:
//   clk   in  1  system clock, rising edge
//   rst   in  1  asynchronous active-low reset
//   en    in  1  count enable (a bit is on the line)
//   tick  out 1  high when the count equals BIT_CYC-1 (last clock of a bit)
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int BIT_CYC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W    = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is always updated with non-blocking (<=)
    // assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || r_cnt == LAST_CNT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The count only leaves 0 while enabled, so no extra gating is needed.
    assign tick = (r_cnt == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Read-side consumer of a byte FIFO that drains it onto an 8N1 UART line.
// Pops one byte whenever the FIFO is non-empty, then sends start bit, eight
// data bits LSB first and a stop bit, each held BIT_CYC clocks.
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous active-low reset
//   fifo_empty  in   1  FIFO empty flag
//   fifo_rdata  in   8  FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     out  1  one-cycle pop strobe
//   tx          out  1  serial line, idle high, registered
//   tx_busy     out  1  high from POP through the end of STOP
//   tx_done     out  1  one-cycle pulse on the last clock of each stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_rdata,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               BIT_CYC  = calc_bit_cyc(CLK_FREQ, BAUD);
    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_tx;
    logic                 r_fifo_rd;
    logic                 r_busy;

    logic                 w_cnt_en;
    logic                 w_tick;
    logic [IDX_W-1:0]     w_next_idx;

    // The baud counter runs only while a bit is on the line; it sits at 0
    // through IDLE/POP/LATCH so START always begins a full bit period.
    assign w_cnt_en   = (r_state == ST_START) || (r_state == ST_DATA) ||
                        (r_state == ST_STOP);
    assign w_next_idx = r_bit_idx + IDX_W'(1);

    uart_baud_cnt #(
        .BIT_CYC (BIT_CYC)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (w_cnt_en),
        .tick (w_tick)
    );

    // tx is launched one edge early at every transition so the pin comes
    // straight from a flop and lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= IDLE_LEVEL;
            r_fifo_rd <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // NOTE: the pop strobe defaults low each cycle so it can only be a
            // single-cycle pulse; the branches below raise it when needed.
            r_fifo_rd <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_tx <= IDLE_LEVEL;
                    if (!fifo_empty) begin
                        r_state   <= ST_POP;
                        r_fifo_rd <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                // The FIFO's registered read data appears during LATCH.
                ST_POP: begin
                    r_state <= ST_LATCH;
                end

                ST_LATCH: begin
                    r_shift <= fifo_rdata;
                    r_tx    <= START_BIT;
                    r_state <= ST_START;
                end

                ST_START: begin
                    if (w_tick) begin
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_tx    <= STOP_BIT;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_shift[w_next_idx];
                        end
                    end
                end

                // Going straight to POP on a non-empty FIFO gives back-to-back
                // frames with only the POP and LATCH clocks of idle between.
                ST_STOP: begin
                    if (w_tick) begin
                        if (!fifo_empty) begin
                            r_state   <= ST_POP;
                            r_fifo_rd <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd = r_fifo_rd;
    assign tx      = r_tx;
    assign tx_busy = r_busy;
    // Decoded from flops only (state and baud count), so no input reaches it.
    assign tx_done = (r_state == ST_STOP) && w_tick;

endmodule
